// File: rtl/montar_pin_if.sv
// Packet type and keypad/verifier bundle for the PIN assembler.
//
// montar_pin_pkg::pinPac_t  - 17-bit packet {status, digit1, digit2, digit3, digit4}
//                             handed to the password verifier.
// montar_pin_if             - the signals between the keypad side and montar_pin:
//   enable        keypad accepted (1) / lockout (0)
//   key_valid     single-cycle strobe qualifying key_code
//   key_code[3:0] 0-9 digit, A clear, B enter, C-F ignored
//   pin_out       packet to the verifier
//   digit_count   digits currently buffered (0..4)
//   busy          submission in progress
//   entry_error   1-cycle pulse: enter with fewer than 4 digits
//   timeout_pulse 1-cycle pulse: buffer dropped by inactivity
// Modports: master = keypad/controller side, slave = montar_pin.

package montar_pin_pkg;

    typedef struct packed {
        logic       status;
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
    } pinPac_t;

endpackage

interface montar_pin_if;
    import montar_pin_pkg::*;

    logic       enable;
    logic       key_valid;
    logic [3:0] key_code;
    pinPac_t    pin_out;
    logic [2:0] digit_count;
    logic       busy;
    logic       entry_error;
    logic       timeout_pulse;

    modport master (
        output enable, key_valid, key_code,
        input  pin_out, digit_count, busy, entry_error, timeout_pulse
    );

    modport slave (
        input  enable, key_valid, key_code,
        output pin_out, digit_count, busy, entry_error, timeout_pulse
    );

endinterface

// File: rtl/montar_pin.sv
// Keypad-side PIN assembler.
//
// Collects decoded key strobes into a 4-digit shift buffer (newest digit in
// digit1) and, on enter with a full buffer, holds pin_out.status high for
// HOLD_CYCLES cycles followed by one quiet cycle, so the verifier sees exactly
// one rising edge per submission. Clear, short enter, inactivity timeout and
// lockout (enable=0) all discard the buffer.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - montar_pin_if.slave: enable/key_valid/key_code in;
//          pin_out/digit_count/busy/entry_error/timeout_pulse out
//
// Parameters:
//   TIMEOUT_CYCLES - idle cycles in COLLECT before the buffer is dropped (>= 2)
//   HOLD_CYCLES    - cycles pin_out.status stays high per submission (>= 1)

module montar_pin
    import montar_pin_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int HOLD_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    montar_pin_if.slave bus
);

    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam pinPac_t PIN_EMPTY = '{status: 1'b0, digit1: 4'hF, digit2: 4'hF,
                                      digit3: 4'hF, digit4: 4'hF};

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_SEND,
        S_GAP
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  tmr;
    logic [HOLD_W-1:0] hold_cnt;
    pinPac_t           pin_q;
    logic [2:0]        count_q;
    logic              busy_q;
    logic              err_q;
    logic              to_q;

    logic key_digit;
    logic key_clear;
    logic key_enter;

    assign key_digit = bus.key_valid && (bus.key_code <= 4'd9);
    assign key_clear = bus.key_valid && (bus.key_code == 4'hA);
    assign key_enter = bus.key_valid && (bus.key_code == 4'hB);

    // NOTE: every state register uses non-blocking assignments so all of them
    // update together on the edge, whatever order the statements appear in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tmr      <= '0;
            hold_cnt <= '0;
            pin_q    <= PIN_EMPTY;
            count_q  <= 3'd0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            // Both pulses are single-cycle: default low, set only where raised.
            err_q <= 1'b0;
            to_q  <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Clear, enter and ignored codes do nothing here; the
                    // buffer is already empty, so lockout needs no action.
                    if (bus.enable && key_digit) begin
                        pin_q   <= '{status: 1'b0, digit1: bus.key_code, digit2: pin_q.digit1,
                                     digit3: pin_q.digit2, digit4: pin_q.digit3};
                        count_q <= 3'd1;
                        tmr     <= '0;
                        state   <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    if (!bus.enable) begin
                        pin_q   <= PIN_EMPTY;
                        count_q <= 3'd0;
                        tmr     <= '0;
                        state   <= S_IDLE;
                    end else if (key_digit) begin
                        // Shift even when full so the buffer keeps the last four.
                        pin_q   <= '{status: 1'b0, digit1: bus.key_code, digit2: pin_q.digit1,
                                     digit3: pin_q.digit2, digit4: pin_q.digit3};
                        if (count_q != 3'd4) begin
                            count_q <= count_q + 3'd1;
                        end
                        tmr     <= '0;
                    end else if (key_clear) begin
                        pin_q   <= PIN_EMPTY;
                        count_q <= 3'd0;
                        tmr     <= '0;
                        state   <= S_IDLE;
                    end else if (key_enter) begin
                        if (count_q == 3'd4) begin
                            pin_q.status <= 1'b1;
                            busy_q       <= 1'b1;
                            hold_cnt     <= '0;
                            tmr          <= '0;
                            state        <= S_SEND;
                        end else begin
                            err_q   <= 1'b1;
                            pin_q   <= PIN_EMPTY;
                            count_q <= 3'd0;
                            tmr     <= '0;
                            state   <= S_IDLE;
                        end
                    end else if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        // This idle cycle is the TIMEOUT_CYCLES-th since the
                        // last accepted key. A key arriving now took the
                        // branches above instead, so the key wins.
                        to_q    <= 1'b1;
                        pin_q   <= PIN_EMPTY;
                        count_q <= 3'd0;
                        tmr     <= '0;
                        state   <= S_IDLE;
                    end else begin
                        // Ignored codes 0xC-0xF land here and do not reload.
                        tmr <= tmr + TMR_W'(1);
                    end
                end

                S_SEND: begin
                    // Keys and enable are ignored until the submission ends.
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        pin_q.status <= 1'b0;
                        state        <= S_GAP;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                S_GAP: begin
                    pin_q   <= PIN_EMPTY;
                    count_q <= 3'd0;
                    busy_q  <= 1'b0;
                    state   <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pin_out       = pin_q;
    assign bus.digit_count   = count_q;
    assign bus.busy          = busy_q;
    assign bus.entry_error   = err_q;
    assign bus.timeout_pulse = to_q;

endmodule

// File: tb/tb_montar_pin.sv
// Self-checking bench for montar_pin.
//
// A behavioural model (queue of typed digits, idle-cycle count, remaining
// submission window) predicts every output after each clock edge; a compare
// process checks all outputs on every falling edge. Directed sequences add
// hand-computed literal expectations at the key moments.

`timescale 1ns/1ps

module tb_montar_pin;
    import montar_pin_pkg::*;

    localparam int T    = 10;
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    montar_pin_if bus();

    montar_pin #(
        .TIMEOUT_CYCLES(T),
        .HOLD_CYCLES   (HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_q[$];     // typed digits, newest first, at most 4 kept
    int m_idle;     // cycles without an accepted key while digits are held
    int m_left;     // cycles left in a submission (status + quiet cycle)
    bit m_err;
    bit m_to;

    function automatic logic [3:0] m_digit(input int k);
        return (m_q.size() > k) ? 4'(m_q[k]) : 4'hF;
    endfunction

    function automatic logic [16:0] exp_pin();
        return {(m_left > 1) ? 1'b1 : 1'b0, m_digit(0), m_digit(1), m_digit(2), m_digit(3)};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_idle = 0;
        m_left = 0;
        m_err  = 0;
        m_to   = 0;
    endtask

    task automatic model_flush();
        m_q.delete();
        m_idle = 0;
    endtask

    task automatic model_step(input logic en, input logic kv, input logic [3:0] kc);
        m_err = 0;
        m_to  = 0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) model_flush();
        end else if (!en) begin
            model_flush();
        end else if (kv && kc <= 4'd9) begin
            m_q.push_front(int'(kc));
            if (m_q.size() > 4) void'(m_q.pop_back());
            m_idle = 0;
        end else if (m_q.size() != 0) begin
            if (kv && kc == 4'hA) begin
                model_flush();
            end else if (kv && kc == 4'hB) begin
                if (m_q.size() == 4) begin
                    m_left = HOLD + 1;
                end else begin
                    m_err = 1;
                    model_flush();
                end
            end else begin
                m_idle++;
                if (m_idle == T) begin
                    m_to = 1;
                    model_flush();
                end
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("pin_out",       bus.pin_out,       exp_pin());
        check("digit_count",   bus.digit_count,   m_q.size());
        check("busy",          bus.busy,          (m_left > 0) ? 1 : 0);
        check("entry_error",   bus.entry_error,   m_err);
        check("timeout_pulse", bus.timeout_pulse, m_to);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic en, input logic kv, input logic [3:0] kc);
        bus.enable    = en;
        bus.key_valid = kv;
        bus.key_code  = kc;
        @(posedge clk);
        model_step(en, kv, kc);
        #1;
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b1, 1'b1, kc);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 4'h0);
    endtask

    task automatic type_1234();
        key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.enable    = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        model_reset();
        #1;
        check("reset pin_out",  bus.pin_out,       17'h0FFFF);
        check("reset count",    bus.digit_count,   0);
        check("reset busy",     bus.busy,          0);
        check("reset error",    bus.entry_error,   0);
        check("reset timeout",  bus.timeout_pulse, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic submission: status two cycles, quiet cycle, then flush.
        type_1234();
        key(4'hB);
        check("1234 first status", bus.pin_out, 17'h14321);
        check("1234 busy", bus.busy, 1);
        idle(1);
        check("1234 second status", bus.pin_out, 17'h14321);
        idle(1);
        check("1234 gap", bus.pin_out, 17'h04321);
        check("1234 gap busy", bus.busy, 1);
        idle(1);
        check("1234 flushed", bus.pin_out, 17'h0FFFF);
        check("1234 count", bus.digit_count, 0);
        check("1234 busy done", bus.busy, 0);

        // Short entry.
        key(4'h5); key(4'h6); key(4'hB);
        check("short error", bus.entry_error, 1);
        check("short status", bus.pin_out.status, 0);
        check("short count", bus.digit_count, 0);
        idle(1);
        check("short error done", bus.entry_error, 0);

        // Six digits keep the last four.
        for (int d = 1; d <= 6; d++) key(4'(d));
        check("six count sat", bus.digit_count, 4);
        key(4'hB);
        check("six submitted", bus.pin_out, 17'h16543);
        idle(4);

        // Clear then a good entry.
        key(4'h7); key(4'h8); key(4'h9); key(4'hA);
        check("clear buffer", bus.pin_out, 17'h0FFFF);
        check("clear count", bus.digit_count, 0);
        type_1234();
        key(4'hB);
        check("after clear", bus.pin_out, 17'h14321);
        idle(4);

        // Inactivity timeout after exactly T idle cycles.
        key(4'h3);
        idle(T - 1);
        check("timeout not yet", bus.timeout_pulse, 0);
        idle(1);
        check("timeout pulse", bus.timeout_pulse, 1);
        check("timeout buffer", bus.pin_out, 17'h0FFFF);
        idle(1);
        check("timeout once", bus.timeout_pulse, 0);

        // Key on the expiry cycle wins; an ignored code does not reload.
        key(4'h3);
        idle(T - 1);
        key(4'h4);
        check("expiry key count", bus.digit_count, 2);
        check("expiry key no timeout", bus.timeout_pulse, 0);
        key(4'hC);
        idle(T - 2);
        check("ignored code no reload", bus.timeout_pulse, 0);
        idle(1);
        check("ignored code timeout", bus.timeout_pulse, 1);
        idle(1);

        // Keys during SEND and GAP are ignored.
        type_1234();
        key(4'hB);
        key(4'h5);
        check("send ignores key", bus.pin_out, 17'h14321);
        key(4'h6);
        check("gap ignores key", bus.pin_out, 17'h04321);
        key(4'h7);
        check("post gap count", bus.digit_count, 0);
        idle(2);

        // Lockout mid-COLLECT flushes silently.
        key(4'h1); key(4'h2);
        step(1'b0, 1'b1, 4'h3);
        check("lockout buffer", bus.pin_out, 17'h0FFFF);
        check("lockout count", bus.digit_count, 0);
        check("lockout no error", bus.entry_error, 0);
        check("lockout no timeout", bus.timeout_pulse, 0);
        step(1'b0, 1'b0, 4'h0);

        // Lockout during SEND lets the submission finish.
        key(4'h9); key(4'h8); key(4'h7); key(4'h6); key(4'hB);
        step(1'b0, 1'b0, 4'h0);
        check("lockout send", bus.pin_out, 17'h16789);
        step(1'b0, 1'b0, 4'h0);
        check("lockout gap", bus.pin_out, 17'h06789);
        step(1'b0, 1'b0, 4'h0);
        check("lockout send done", bus.busy, 0);

        // Clear and enter in IDLE do nothing.
        key(4'hA); key(4'hB);
        check("idle enter no error", bus.entry_error, 0);
        check("idle count", bus.digit_count, 0);
        idle(1);

        // Reset during SEND drops status at once.
        type_1234();
        key(4'hB);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("reset in send", bus.pin_out.status, 0);
        check("reset in send busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        type_1234();
        key(4'hB);
        check("after reset submit", bus.pin_out, 17'h14321);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/montar_pin.md
Name: montar_pin

Overview:
- Keypad-side PIN assembler that produces the pinPac_t packet consumed by the password verifier.
- Collects decoded key strobes into a 4-digit buffer and handles clear, enter and inactivity timeout.
- On a valid enter, raises pin_out.status for a bounded window, so the verifier sees exactly one rising edge per submission.
- Sits between the keypad decoder and the verifier in the door-lock top level.

Parameters:
- TIMEOUT_CYCLES, 5000000: inactivity cycles after the last accepted key before the buffer is discarded (minimum 2).
- HOLD_CYCLES, 2: cycles pin_out.status stays high per submission (minimum 1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- enable  input  1  1 = keypad accepted; 0 = lockout, keys ignored and buffer flushed.
- key_valid  input  1  single-cycle strobe, key_code valid.
- key_code  input  4  0x0-0x9 = digit, 0xA = clear (*), 0xB = enter (#), 0xC-0xF ignored.
- pin_out  output  pinPac_t (17: status + digit1..digit4, 4 bits each)  packet to the verifier.
- digit_count  output  3  digits currently buffered, 0..4.
- busy  output  1  high in SEND and GAP.
- entry_error  output  1  1-cycle pulse: enter pressed with fewer than 4 digits.
- timeout_pulse  output  1  1-cycle pulse: buffer discarded by inactivity.

Behaviour:
- Reset values:
  - pin_out.status = 0; digit1..digit4 = 4'hF; digit_count = 0.
  - busy = 0; entry_error = 0; timeout_pulse = 0.
  - State = IDLE; timeout counter = 0.
  - Reset mid-SEND drops status to 0 at once.
- Digit order: on an accepted digit, digit4<=digit3, digit3<=digit2, digit2<=digit1, digit1<=key_code. Typing 1,2,3,4 therefore gives digit4=1, digit3=2, digit2=3, digit1=4.
- digit_count saturates at 4. A 5th+ digit still shifts (oldest discarded), so the buffer always holds the last 4 digits typed.
- States:
  - IDLE: count 0, buffer all F. A digit key goes to COLLECT. Clear and enter keys do nothing, with no error pulse.
  - COLLECT:
    - Digit: shift the digit in and reload the timeout counter.
    - Clear: flush the buffer to F and go to IDLE.
    - Enter with count<4: pulse entry_error the next cycle, flush, go to IDLE.
    - Enter with count==4: go to SEND; pin_out.status=1 from the next cycle.
    - Counter reaching TIMEOUT_CYCLES with no key: flush, pulse timeout_pulse, go to IDLE.
  - SEND: status=1 and digits frozen for exactly HOLD_CYCLES cycles, then go to GAP. All keys are ignored.
  - GAP: status=0 with digits still valid for 1 cycle. Then flush the buffer to F, set count=0, go to IDLE.
- Latency: enter strobe at cycle N gives status=1 at N+1..N+HOLD_CYCLES and status=0 at N+HOLD_CYCLES+1.
- Timeout counter: counts only in COLLECT, reloads on every accepted key, width $clog2(TIMEOUT_CYCLES+1).
- Simultaneous key_valid and timeout expiry in the same cycle: the key wins, and there is no timeout.
- enable:
  - enable=0 in IDLE or COLLECT: flush, go to IDLE, no pulses, key ignored.
  - enable=0 during SEND or GAP: the submission completes normally.
- key_valid held high for several cycles counts as one key per cycle (the upstream debouncer guarantees single strobes).
- Ignored codes 0xC-0xF do not reload the timeout counter.
- entry_error and timeout_pulse are never high together and never last more than 1 cycle.

Test Plan:
- Keys 1,2,3,4 then 0xB -> status high for exactly 2 cycles, digit4..digit1 = 1,2,3,4, busy high for 3 cycles. Then buffer = FFFF and digit_count = 0.
- Keys 5,6 then 0xB -> entry_error pulses 1 cycle, status never rises, digit_count returns to 0.
- Keys 1..6 then 0xB -> submitted digit4..digit1 = 3,4,5,6.
- Keys 7,8,9 then 0xA -> buffer FFFF, IDLE. Then 1,2,3,4,0xB submits 1234 correctly.
- TIMEOUT_CYCLES=10: key 3, wait 10 idle cycles -> timeout_pulse once, buffer FFFF. Repeat with a key on the expiry cycle -> no timeout, count=2.
- Keys pressed during SEND are ignored. Drop enable mid-COLLECT -> flush with no pulse. Assert rst during SEND -> status=0 immediately.
